fetch_line: RTL
===============

FETCH_LINE -- requirements
Module: fetch_line

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64: bus beat width in bits.
REQ-002 Parameter BUS_TAG_WIDTH, default 13: bus tag width in bits.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 entry  in  64  start PC, loaded while reset is low.
REQ-006 bus_reqcyc  out  1  bus request valid.
REQ-007 bus_req  out  64  request address, always 64-byte aligned.
REQ-008 bus_reqtag  out  BUS_TAG_WIDTH  request tag, constant FETCH_TAG.
REQ-009 bus_reqack  in  1  bus accepted the request.
REQ-010 bus_respcyc  in  1  response beat valid.
REQ-011 bus_resp  in  BUS_DATA_WIDTH  response beat data.
REQ-012 bus_respack  out  1  beat consumed.
REQ-013 instr  out  32  instruction word to decoder.
REQ-014 instr_pc  out  64  PC of instr.
REQ-015 instr_valid  out  1  instr/instr_pc valid.
REQ-016 instr_ready  in  1  decoder accepts instr this cycle.
REQ-017 redirect  in  1  control-flow change request.
REQ-018 redirect_pc  in  64  new PC; bits [1:0] are ignored and forced to 0.

Function
REQ-019 FSM states: REQ, RESP, DRAIN, FLUSH.
- Reset enters REQ with pc = entry & ~3.
REQ-020 REQ state:
- bus_reqcyc=1, bus_req = {pc[63:6], 6'b0}.
- The address is latched on entry and held unchanged until bus_reqack.
- On bus_reqack: go to FLUSH if a redirect is pending, else go to RESP; beat count = 0.
REQ-021 RESP state:
- bus_respack = bus_respcyc, combinationally.
- Each beat with bus_respcyc=1 is written to line-buffer slot beat[2:0].
- Beat count increments modulo 8.
- After beat 7 is accepted, go to DRAIN on the next cycle.
REQ-022 Instruction order: beat k holds instruction 2k in bits [31:0] and instruction 2k+1 in bits [63:32].
REQ-023 DRAIN state:
- instr = buffer instruction at index pc[5:2]; instr_pc = pc.
- instr_valid = 1 unless redirect is high that cycle.
REQ-024 Handshake:
- A transfer occurs when instr_valid and instr_ready are both 1; pc then increments by 4.
- instr and instr_pc hold stable while instr_valid=1 and instr_ready=0.
REQ-025 Line end: a transfer at index 15 moves to REQ for the next line (pc+4).
- 64-bit wrap of pc is permitted silently.
REQ-026 instr_valid = 0 in the REQ, RESP and FLUSH states.
- Instruction words are passed through unmodified; all-zero words are not filtered.
REQ-027 Redirect has the highest priority in every state.
- On redirect, pc <= redirect_pc & ~3.
- Any transfer coinciding with redirect is discarded: instr_valid is forced to 0.
REQ-028 Redirect in DRAIN goes to REQ and always refetches, even when the target is in the same line.
REQ-029 Redirect in REQ before bus_reqack sets a pending flag.
- The outstanding request completes, then the FSM moves to FLUSH.
REQ-030 Redirect in RESP moves to FLUSH.
- The beat count is preserved.
- Remaining beats are still acknowledged.
REQ-031 FLUSH state:
- Beats are acked and counted but not used for instructions.
- After beat 7, go to REQ with the latest pc.
- A redirect during FLUSH only updates pc.
REQ-032 Only one bus request is ever outstanding.
REQ-033 bus_respack is never asserted in the REQ or DRAIN states.

Reset
REQ-034 While reset is low:
- bus_reqcyc=0, bus_respack=0, instr_valid=0.
- instr=0, instr_pc=0.
- Beat count = 0; pending flag cleared; pc = entry & ~3.
REQ-035 First request: bus_reqcyc is asserted on the first cycle after reset rises.
REQ-036 Reset mid-transaction abandons the transaction; the bus side is responsible for dropping it.

Structure
REQ-037 Shared package contents:
- FETCH_TAG.
- LINE_BYTES=64, BEATS_PER_LINE=8.
- Fetch FSM state enum.
REQ-038 One sub-module, fetch_line_buf:
- 8x64 line buffer with write port (slot, data, we).
- Read port selecting 32-bit word by a 4-bit index.
REQ-039 Target size: 120-400 lines of RTL, no other sub-modules.

Verification
REQ-040 Cold start: entry=0x1008; ack after 2 cycles; 8 beats.
- bus_req=0x1000.
- First instr has instr_pc=0x1008 and equals beat1[31:0].
- 14 instructions are delivered, then a request to 0x1040.
REQ-041 Backpressure: instr_ready=0 for 5 cycles in DRAIN.
- instr and instr_pc are stable, with no pc advance.
- Release gives consecutive instr_pc values 0x1008, 0x100C.
REQ-042 Redirect in RESP after beat 3, redirect_pc=0x2006.
- Beats 4-7 are acked with no instr_valid.
- Next bus_req=0x2000; first instr_pc=0x2004.
REQ-043 Redirect in REQ before ack, redirect_pc=0x3000.
- bus_req stays 0x1000 until ack, then 8 beats are flushed.
- Next bus_req=0x3000.
REQ-044 Redirect together with instr_ready=1 in DRAIN.
- instr_valid=0 that cycle.
- No transfer counted; next request uses the redirect target.
REQ-045 Reset low during RESP beat 5.
- All outputs return to their reset values.
- After release, bus_req = {entry[63:6], 6'b0}.

Source files
------------

// File: rtl/fetch_line_pkg.sv
// Shared definitions for the instruction line fetcher: bus tag, line geometry
// and the fetch FSM state encoding.
package fetch_line_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_OFF_W     = $clog2(LINE_BYTES);

  // Tag carried on every fetch request so the bus can route the response back.
  localparam logic [12:0] FETCH_TAG = 13'h1F5;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_RESP  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_line_buf.sv
// One cache line of instruction storage: eight bus beats written by slot,
// read back as sixteen 32-bit instruction words.
module fetch_line_buf
  import fetch_line_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [2:0]        slot_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        idx_i,
  output logic [31:0]       word_o
);

  logic [DATA_W-1:0] mem_q [BEATS_PER_LINE];

  // Capture a response beat into its slot; line data is never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[slot_i] <= data_i;
    end
  end

  // Even word indices live in the low half of a beat, odd ones in the high half.
  always_comb begin
    word_o = idx_i[0] ? mem_q[idx_i[3:1]][63:32] : mem_q[idx_i[3:1]][31:0];
  end

endmodule

// File: rtl/fetch_line.sv
// Instruction fetcher: requests one 64-byte line at a time, collects its eight
// beats into a line buffer, then hands instructions to the decoder one per
// handshake. Redirects win over everything and always force a fresh fetch.
module fetch_line
  import fetch_line_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic                      bus_respack,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_LINE - 1);

  fetch_state_e            state_q, state_d;
  logic [63:0]             pc_q, pc_d;
  logic [63:LINE_OFF_W]    req_line_q, req_line_d;
  logic [2:0]              beat_q, beat_d;
  logic                    pend_q, pend_d;
  logic                    beat_fire;
  logic                    xfer;
  logic                    buf_we;
  logic [31:0]             buf_word;

  fetch_line_buf #(
    .DATA_W (BUS_DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .slot_i (beat_q),
    .data_i (bus_resp),
    .idx_i  (pc_q[5:2]),
    .word_o (buf_word)
  );

  // Bus and decoder outputs; everything is quiet while reset is held low.
  always_comb begin
    beat_fire   = bus_respcyc && (state_q == ST_RESP || state_q == ST_FLUSH);
    buf_we      = reset && bus_respcyc && (state_q == ST_RESP);
    bus_reqcyc  = reset && (state_q == ST_REQ);
    bus_req     = {req_line_q, {LINE_OFF_W{1'b0}}};
    bus_reqtag  = BUS_TAG_WIDTH'(FETCH_TAG);
    bus_respack = reset && beat_fire;
    instr_valid = reset && (state_q == ST_DRAIN) && !redirect;
    instr       = reset ? buf_word : 32'd0;
    instr_pc    = reset ? pc_q : 64'd0;
    xfer        = instr_valid && instr_ready;
  end

  // Next-state logic: per-state progress first, then redirect overrides pc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    req_line_d = req_line_q;
    case (state_q)
      ST_REQ: begin
        if (bus_reqack) begin
          beat_d  = 3'd0;
          pend_d  = 1'b0;
          state_d = (pend_q || redirect) ? ST_FLUSH : ST_RESP;
        end else if (redirect) begin
          pend_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (beat_fire) begin
          beat_d = beat_q + 3'd1;
        end
        // A redirect on the final beat has nothing left to flush.
        if (beat_fire && beat_q == LAST_BEAT) begin
          state_d = redirect ? ST_REQ : ST_DRAIN;
        end else if (redirect) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (beat_fire) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (xfer) begin
          pc_d = pc_q + 64'd4;
          if (pc_q[5:2] == 4'hF) begin
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_REQ;
    endcase
    if (redirect) begin
      pc_d = redirect_pc & ~64'd3;
    end
    // Latch the request address once on entry to REQ so it holds until ack.
    if (state_d == ST_REQ && state_q != ST_REQ) begin
      req_line_d = pc_d[63:LINE_OFF_W];
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_REQ;
      pc_q       <= entry & ~64'd3;
      req_line_q <= entry[63:LINE_OFF_W];
      beat_q     <= 3'd0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_line_q <= req_line_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
    end
  end

endmodule
